// File: rtl/glitc_intercom_lane_align_pkg.sv
// Shared types and constants for the GLITC intercom lane-alignment trainer.
package glitc_intercom_lane_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_SLIP,
    ST_NEXT,
    ST_DONE
  } align_state_e;

  localparam logic [3:0] TRAIN_PATTERN_DEF = 4'h3;
  localparam int         MATCH_W           = 8;
  localparam int         SLIP_W            = 4;
  localparam int         SETTLE_W          = 8;

  // A single-lane build still needs a 1-bit lane index.
  function automatic int lane_idx_w(input int nbits);
    return (nbits > 1) ? $clog2(nbits) : 1;
  endfunction

endpackage

// File: rtl/glitc_intercom_lane_check.sv
// Per-word training-pattern compare with a consecutive-match counter.
module glitc_intercom_lane_check
  import glitc_intercom_lane_align_pkg::*;
#(
  parameter logic [3:0] TRAIN_PATTERN = TRAIN_PATTERN_DEF,
  parameter int         CHECK_LEN     = 16
) (
  input  logic       sysclk_i,
  input  logic       clr_i,
  input  logic [3:0] word_i,
  output logic       match_o,
  output logic       pass_o
);

  logic [MATCH_W-1:0] match_cnt_q;

  assign match_o = (word_i == TRAIN_PATTERN);
  // pass fires on the matching word that would bring the run to CHECK_LEN
  assign pass_o  = match_o && (match_cnt_q == MATCH_W'(CHECK_LEN - 1));

  always_ff @(posedge sysclk_i) begin
    if (clr_i || !match_o) begin
      match_cnt_q <= '0;
    end else if (match_cnt_q != MATCH_W'(CHECK_LEN)) begin
      match_cnt_q <= match_cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/glitc_intercom_lane_align.sv
// Word-alignment trainer: walks the lanes in order, bitslipping each until the
// training nibble is seen CHECK_LEN times in a row or MAX_SLIPS is exhausted.
//   state  | meaning
//   IDLE   | waiting for a train_i rising edge
//   SETTLE | letting the ISERDES settle after a slip or lane change
//   CHECK  | comparing the current lane against the training nibble
//   SLIP   | bitslip pulse on the lane under test
//   NEXT   | advance to the next lane or finish
//   DONE   | drop busy, raise done
module glitc_intercom_lane_align
  import glitc_intercom_lane_align_pkg::*;
#(
  parameter int         NBITS         = 4,
  parameter logic [3:0] TRAIN_PATTERN = TRAIN_PATTERN_DEF,
  parameter int         CHECK_LEN     = 16,
  parameter int         SETTLE_CYC    = 8,
  parameter int         MAX_SLIPS     = 8
) (
  input  logic               sysclk_i,
  input  logic               rst_n_i,
  input  logic [4*NBITS-1:0] data_i,
  input  logic               train_i,
  output logic [NBITS-1:0]   bitslip_o,
  output logic [NBITS-1:0]   aligned_o,
  output logic [NBITS-1:0]   fail_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int LANE_W = lane_idx_w(NBITS);

  align_state_e        state_q, state_d;
  logic                train_q;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [SLIP_W-1:0]   slips_q, slips_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [NBITS-1:0]    aligned_q, aligned_d;
  logic [NBITS-1:0]    fail_q, fail_d;
  logic [NBITS-1:0]    bitslip_q, bitslip_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [3:0]          lane_word;
  logic [NBITS-1:0]    lane_bit;
  logic                word_match;
  logic                lane_pass;
  logic                chk_clr;

  assign lane_word = data_i[4*lane_q +: 4];
  assign lane_bit  = NBITS'(1) << lane_q;
  assign chk_clr   = !rst_n_i || (state_q != ST_CHECK);

  glitc_intercom_lane_check #(
    .TRAIN_PATTERN (TRAIN_PATTERN),
    .CHECK_LEN     (CHECK_LEN)
  ) u_lane_check (
    .sysclk_i (sysclk_i),
    .clr_i    (chk_clr),
    .word_i   (lane_word),
    .match_o  (word_match),
    .pass_o   (lane_pass)
  );

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    slips_d   = slips_q;
    settle_d  = settle_q;
    aligned_d = aligned_q;
    fail_d    = fail_q;
    busy_d    = busy_q;
    done_d    = done_q;
    bitslip_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (train_i && !train_q) begin
          aligned_d = '0;
          fail_d    = '0;
          done_d    = 1'b0;
          lane_d    = '0;
          slips_d   = '0;
          busy_d    = 1'b1;
          settle_d  = SETTLE_W'(SETTLE_CYC - 1);
          state_d   = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_q == '0) state_d = ST_CHECK;
        else                settle_d = settle_q - 1'b1;
      end
      ST_CHECK: begin
        if (lane_pass) begin
          aligned_d = aligned_q | lane_bit;
          state_d   = ST_NEXT;
        end else if (!word_match) begin
          if (slips_q >= SLIP_W'(MAX_SLIPS)) begin
            fail_d  = fail_q | lane_bit;
            state_d = ST_NEXT;
          end else begin
            // registered pulse lands in the SLIP cycle itself
            bitslip_d = lane_bit;
            state_d   = ST_SLIP;
          end
        end
      end
      ST_SLIP: begin
        slips_d  = slips_q + 1'b1;
        settle_d = SETTLE_W'(SETTLE_CYC - 1);
        state_d  = ST_SETTLE;
      end
      ST_NEXT: begin
        if (lane_q == LANE_W'(NBITS - 1)) begin
          state_d = ST_DONE;
        end else begin
          lane_d   = lane_q + 1'b1;
          slips_d  = '0;
          settle_d = SETTLE_W'(SETTLE_CYC - 1);
          state_d  = ST_SETTLE;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      train_q   <= 1'b0;
      lane_q    <= '0;
      slips_q   <= '0;
      settle_q  <= '0;
      aligned_q <= '0;
      fail_q    <= '0;
      bitslip_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      train_q   <= train_i;
      lane_q    <= lane_d;
      slips_q   <= slips_d;
      settle_q  <= settle_d;
      aligned_q <= aligned_d;
      fail_q    <= fail_d;
      bitslip_q <= bitslip_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bitslip_o = bitslip_q;
  assign aligned_o = aligned_q;
  assign fail_o    = fail_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_glitc_intercom_lane_align.sv
// Bench for the lane-alignment trainer: an ISERDES-like lane model that rotates a
// lane per bitslip, a table of directed cases and randomized cases from a timing model.
module tb_glitc_intercom_lane_align;

  localparam int S = 8;
  localparam int C = 16;
  localparam int M = 8;

  typedef struct {
    logic [3:0] stuck;
    logic [3:0] rot;
    int         off[4];
    int         glitch_at;
    int         retrig_at;
    logic [3:0] exp_al;
    logic [3:0] exp_fail;
    int         exp_cyc;
    int         exp_pulses;
  } vec_t;

  logic        sysclk_i = 1'b0;
  logic        rst_n_i  = 1'b0;
  logic        train_i  = 1'b0;
  logic [15:0] data_i;
  logic [3:0]  bitslip_o, aligned_o, fail_o;
  logic        busy_o, done_o;

  int total = 0;
  int bad   = 0;

  logic       clr_mon = 1'b1;
  logic [3:0] stuck   = 4'h0;
  logic [3:0] rot_en  = 4'hF;
  logic       glitch  = 1'b0;
  int off_init[4] = '{0, 0, 0, 0};
  int off[4];
  int pulses[4];
  int last[4];
  int cyc = 0;
  int spacing_err = 0;
  int onehot_err  = 0;

  always #5 sysclk_i = ~sysclk_i;

  glitc_intercom_lane_align dut (
    .sysclk_i  (sysclk_i),
    .rst_n_i   (rst_n_i),
    .data_i    (data_i),
    .train_i   (train_i),
    .bitslip_o (bitslip_o),
    .aligned_o (aligned_o),
    .fail_o    (fail_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  function automatic logic [3:0] rotl(input logic [3:0] p, input int n);
    logic [7:0] t;
    t = {p, p} << n;
    return t[7:4];
  endfunction

  always_comb begin
    data_i = '0;
    for (int i = 0; i < 4; i++) data_i[4*i +: 4] = stuck[i] ? 4'h0 : rotl(4'h3, off[i]);
    if (glitch) data_i[3:0] = ~data_i[3:0];
  end

  // lane model: each bitslip advances the lane's rotation by one bit
  always @(negedge sysclk_i) begin
    cyc++;
    if (clr_mon) begin
      for (int i = 0; i < 4; i++) begin
        off[i] = off_init[i];
        pulses[i] = 0;
        last[i] = -1;
      end
      spacing_err = 0;
      onehot_err = 0;
    end else begin
      if ($countones(bitslip_o) > 1) onehot_err++;
      for (int i = 0; i < 4; i++) begin
        if (bitslip_o[i]) begin
          pulses[i]++;
          if (last[i] >= 0 && cyc - last[i] != S + 2) spacing_err++;
          last[i] = cyc;
          if (rot_en[i]) off[i] = (off[i] + 1) % 4;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] st, input logic [3:0] rt,
                              input int o0, input int o1, input int o2, input int o3,
                              input int g, input int r, input logic [3:0] al,
                              input logic [3:0] fl, input int cy, input int pu);
    vec_t v;
    v.stuck = st; v.rot = rt;
    v.off[0] = o0; v.off[1] = o1; v.off[2] = o2; v.off[3] = o3;
    v.glitch_at = g; v.retrig_at = r;
    v.exp_al = al; v.exp_fail = fl; v.exp_cyc = cy; v.exp_pulses = pu;
    return v;
  endfunction

  // Timing model: lanes are trained in order; a misaligned lane costs one
  // settle+check+slip per slip, a stuck lane exhausts every slip and fails.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int k;
    r = v;
    r.exp_cyc = 1;
    r.exp_pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (v.stuck[i]) begin
        r.exp_cyc += M * (S + 2) + S + 2;
        r.exp_pulses += M;
      end else begin
        k = (4 - v.off[i]) % 4;
        r.exp_cyc += k * (S + 2) + S + C + 1;
        r.exp_pulses += k;
      end
    end
    r.exp_al = ~v.stuck;
    r.exp_fail = v.stuck;
    return r;
  endfunction

  task automatic setup(input vec_t v);
    stuck = v.stuck;
    rot_en = v.rot;
    for (int i = 0; i < 4; i++) off_init[i] = v.off[i];
    clr_mon = 1'b1;
    repeat (2) @(negedge sysclk_i);
    clr_mon = 1'b0;
    @(negedge sysclk_i);
  endtask

  task automatic run_train(input bit hold, input int glitch_at, input int retrig_at,
                           input int rst_at, output int edges, output int busy_err);
    int k;
    edges = -1;
    busy_err = 0;
    k = 0;
    train_i = 1'b1;
    while (k < 3000) begin
      @(negedge sysclk_i);
      k++;
      glitch = (k == glitch_at);
      if (!hold && k == 1) train_i = 1'b0;
      if (retrig_at > 0 && k == retrig_at) train_i = 1'b1;
      if (retrig_at > 0 && k == retrig_at + 1) train_i = 1'b0;
      if (rst_at > 0 && k == rst_at) rst_n_i = 1'b0;
      if (rst_at > 0 && k == rst_at + 1) begin
        chk("rst_bitslip", bitslip_o, 0);
        chk("rst_aligned", aligned_o, 0);
        chk("rst_fail", fail_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        rst_n_i = 1'b1;
        edges = -2;
        break;
      end
      if (done_o) begin
        edges = k - 1;
        break;
      end
      if (busy_o !== 1'b1) busy_err++;
    end
    glitch = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int edges, busy_err;
    setup(v);
    run_train(1'b0, v.glitch_at, v.retrig_at, 0, edges, busy_err);
    chk({tag, "_cycles"}, edges, v.exp_cyc);
    chk({tag, "_aligned"}, aligned_o, v.exp_al);
    chk({tag, "_fail"}, fail_o, v.exp_fail);
    chk({tag, "_exclusive"}, aligned_o & fail_o, 0);
    chk({tag, "_done"}, done_o, 1);
    chk({tag, "_busy_end"}, busy_o, 0);
    chk({tag, "_pulses"}, pulses[0] + pulses[1] + pulses[2] + pulses[3], v.exp_pulses);
    chk({tag, "_busy_hold"}, busy_err, 0);
    chk({tag, "_spacing"}, spacing_err, 0);
    chk({tag, "_onehot"}, onehot_err, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    vec_t v;
    int edges, busy_err;

    tbl[0] = mk(4'h0, 4'hF, 0, 0, 0, 0,  0, -1, 4'hF, 4'h0, 101, 0);
    tbl[1] = mk(4'h0, 4'hF, 0, 0, 2, 0,  0, -1, 4'hF, 4'h0, 121, 2);
    tbl[2] = mk(4'h2, 4'hF, 0, 0, 0, 0,  0, -1, 4'hD, 4'h2, 166, 8);
    tbl[3] = mk(4'h0, 4'hE, 0, 0, 0, 0, 24, -1, 4'hF, 4'h0, 126, 1);
    tbl[4] = mk(4'h0, 4'hF, 0, 0, 0, 0,  0,  5, 4'hF, 4'h0, 101, 0);

    rst_n_i = 1'b0;
    repeat (3) @(negedge sysclk_i);
    chk("reset_bitslip", bitslip_o, 0);
    chk("reset_aligned", aligned_o, 0);
    chk("reset_fail", fail_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_done", done_o, 0);
    rst_n_i = 1'b1;
    @(negedge sysclk_i);

    for (int i = 0; i < 5; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    for (int r = 0; r < 8; r++) begin
      v = mk(4'($urandom_range(0, 15) & $urandom_range(0, 15)), 4'hF,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), 0, -1, 4'h0, 4'h0, 0, 0);
      run_vec(model(v), $sformatf("rand%0d", r));
    end

    // train level held through DONE must not start another run
    setup(tbl[0]);
    run_train(1'b1, 0, -1, 0, edges, busy_err);
    chk("held_cycles", edges, 101);
    repeat (20) @(negedge sysclk_i);
    chk("held_no_retrig_busy", busy_o, 0);
    chk("held_no_retrig_done", done_o, 1);
    train_i = 1'b0;
    @(negedge sysclk_i);

    // reset during lane 1 settle aborts; the stuck lane would otherwise slip
    setup(tbl[2]);
    run_train(1'b0, 0, -1, 28, edges, busy_err);
    chk("rst_abort", edges, -2);
    repeat (40) @(negedge sysclk_i);
    chk("rst_no_pulses", pulses[0] + pulses[1] + pulses[2] + pulses[3], 0);
    chk("rst_idle_busy", busy_o, 0);
    run_vec(tbl[0], "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
